// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder transmitter: FSM states,
// Gray lookup tables and minimum effective transition periods.
// Latency/backpressure: not applicable (declarations only).
package quad_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // (A,B) for phase index 0..3, walking forward: 00 -> 10 -> 11 -> 01.
    localparam logic [3:0][1:0] GRAY_FWD = {2'b01, 2'b11, 2'b10, 2'b00};
    // (A,B) for reverse step count 0..3, walking back: 00 -> 01 -> 11 -> 10.
    localparam logic [3:0][1:0] GRAY_REV = {2'b10, 2'b11, 2'b01, 2'b00};

    localparam int PERIOD_MIN     = 1;
    localparam int PERIOD_MIN_BNC = 3;

endpackage

// File: rtl/quad_enc_timer.sv
// Loadable period down-counter: one-cycle tick every load_val cycles.
// Latency: first tick load_val cycles after start; reloads on tick or start.
// Backpressure: none; counts only while en is high.
// Ports: clk, reset_n (sync, active-low), en, start, load_val, tick.
module quad_enc_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                start,
    input  logic [PERIOD_W-1:0] load_val,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    // Counter holds load_val-1 after a load, so the tick lands on the
    // cycle whose closing edge is exactly load_val edges after the load.
    always_comb begin
        tick  = en && !start && (cnt_q == '0);
        cnt_d = cnt_q;
        if (start || tick) begin
            cnt_d = load_val - PERIOD_W'(1);
        end else if (en) begin
            cnt_d = cnt_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quad_enc_tx.sv
// Quadrature encoder transmitter: emits cmd_steps Gray transitions on enc_a/enc_b.
// Latency: first edge P cycles after handshake, then every P; done P after last.
// Backpressure: cmd_ready only in IDLE; cmd_valid ignored while busy (no queue).
// Ports: clk, reset_n (sync, active-low), cmd_valid/cmd_ready/cmd_dir/
// cmd_steps/cmd_period command channel, enc_a/enc_b (registered), busy, done.
// Build option: define QUAD_ENC_TX_BOUNCE_EN to emulate contact bounce
// (new/old/new on the changed line, minimum period 3).
module quad_enc_tx
    import quad_enc_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic                enc_a,
    output logic                enc_b,
    output logic                busy,
    output logic                done
);

`ifdef QUAD_ENC_TX_BOUNCE_EN
    localparam int P_MIN = PERIOD_MIN_BNC;
`else
    localparam int P_MIN = PERIOD_MIN;
`endif

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [COUNT_W-1:0]  rem_q, rem_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          enc_ab_q, enc_ab_d;
`ifdef QUAD_ENC_TX_BOUNCE_EN
    logic [1:0]          prev_ab_q, prev_ab_d;
    logic [1:0]          bnc_q, bnc_d;
`endif

    logic                hs;
    logic                tick;
    logic [PERIOD_W-1:0] p_eff;
    logic [PERIOD_W-1:0] timer_load;
    logic [1:0]          nxt_phase;
    logic [1:0]          rev_idx;
    logic [1:0]          nxt_ab;

    assign cmd_ready  = reset_n && (state_q == IDLE);
    assign hs         = cmd_valid && cmd_ready;
    assign busy       = (state_q != IDLE);
    assign done       = reset_n && (state_q == HOLD) && tick;
    assign enc_a      = enc_ab_q[1];
    assign enc_b      = enc_ab_q[0];
    assign p_eff      = (cmd_period < PERIOD_W'(P_MIN)) ? PERIOD_W'(P_MIN) : cmd_period;
    // period_q is not yet valid on the handshake cycle, so load straight from the port.
    assign timer_load = hs ? p_eff : period_q;

    // phase_q is always the forward-table index so direction changes between
    // commands continue from the same physical position; the reverse table is
    // indexed by the complementary step count.
    assign nxt_phase = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);
    assign rev_idx   = 2'd0 - nxt_phase;
    assign nxt_ab    = dir_q ? GRAY_FWD[nxt_phase] : GRAY_REV[rev_idx];

    quad_enc_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (busy),
        .start    (hs),
        .load_val (timer_load),
        .tick     (tick)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        period_d = period_q;
        phase_d  = phase_q;
        enc_ab_d = enc_ab_q;
`ifdef QUAD_ENC_TX_BOUNCE_EN
        prev_ab_d = prev_ab_q;
        bnc_d     = bnc_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    dir_d    = cmd_dir;
                    rem_d    = cmd_steps;
                    period_d = p_eff;
                    state_d  = (cmd_steps == '0) ? HOLD : RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    phase_d  = nxt_phase;
                    enc_ab_d = nxt_ab;
                    rem_d    = rem_q - COUNT_W'(1);
`ifdef QUAD_ENC_TX_BOUNCE_EN
                    prev_ab_d = enc_ab_q;
                    bnc_d     = 2'd2;
`endif
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef QUAD_ENC_TX_BOUNCE_EN
        // Two cycles after a transition: show the old level once, then settle
        // back on the new one. The minimum period of 3 keeps this clear of
        // the next transition.
        if (bnc_q == 2'd2) begin
            enc_ab_d = prev_ab_q;
            bnc_d    = 2'd1;
        end else if (bnc_q == 2'd1) begin
            enc_ab_d = GRAY_FWD[phase_q];
            bnc_d    = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            period_q <= '0;
            phase_q  <= 2'd0;
            enc_ab_q <= 2'b00;
`ifdef QUAD_ENC_TX_BOUNCE_EN
            prev_ab_q <= 2'b00;
            bnc_q     <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            enc_ab_q <= enc_ab_d;
`ifdef QUAD_ENC_TX_BOUNCE_EN
            prev_ab_q <= prev_ab_d;
            bnc_q     <= bnc_d;
`endif
        end
    end

endmodule

// File: doc/quad_enc_tx.md
QUAD_ENC_TX -- requirements
Module: quad_enc_tx

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of the per-transition period.
REQ-002 SHALL have parameter COUNT_W, default 8, width of the step count.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_dir  input  1  direction: 1 = forward (A leads), 0 = reverse (B leads).
REQ-008 SHALL have port cmd_steps  input  COUNT_W  number of Gray transitions to emit.
REQ-009 SHALL have port cmd_period  input  PERIOD_W  clock cycles between transitions; 0 is treated as 1.
REQ-010 SHALL have port enc_a  output  1  quadrature phase A, registered.
REQ-011 SHALL have port enc_b  output  1  quadrature phase B, registered.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a command completes.

Function
REQ-014 SHALL drive cmd_ready = 1 only in IDLE with reset_n high; a handshake occurs on any cycle with cmd_valid && cmd_ready.
REQ-015 SHALL latch cmd_dir, cmd_steps and the effective period P on the handshake cycle; later input changes are ignored until the next handshake.
REQ-016 SHALL implement the states IDLE, RUN and HOLD; a handshake moves IDLE->RUN, except that cmd_steps = 0 moves IDLE->HOLD.
REQ-017 SHALL emit the forward Gray sequence (A,B) 00->10->11->01->00.
REQ-018 SHALL emit the reverse Gray sequence 00->01->11->10->00.
REQ-019 SHALL change exactly one of enc_a/enc_b per transition.
REQ-020 SHALL keep the phase position across commands; the block never returns to 00 between commands.
REQ-021 SHALL make the first transition visible P cycles after the handshake edge, and each later transition every P cycles.
REQ-022 SHALL decrement the remaining count on each transition; after the last transition the state moves RUN->HOLD.
REQ-023 SHALL wait P cycles in HOLD, then pulse done for 1 cycle and return to IDLE on that same edge, so cmd_ready = 1 on the cycle after done.
REQ-024 SHALL, for cmd_steps = 0, produce no edges and pulse done P cycles after the handshake.
REQ-025 SHALL give cmd_steps = 2^COUNT_W-1 exactly that many transitions, with no wrap of the remaining count.
REQ-026 SHALL ignore cmd_valid while busy; no queuing.
REQ-027 SHALL make the phase-counter wrap 3->0 seamless in both directions.

Reset
REQ-028 SHALL, on a clock edge with reset_n low, force IDLE, enc_a = 0, enc_b = 0, phase = 0, busy = 0, done = 0, and clear the counters.
REQ-029 SHALL drive cmd_ready = 0 while reset_n is low.
REQ-030 SHALL, on reset in RUN or HOLD, abort the command with no done pulse; the outputs are 00 on the next edge.

Configuration
REQ-031 SHALL, with QUAD_ENC_TX_BOUNCE_EN defined, emulate contact bounce on every transition: the changed line shows new, old, new values on 3 consecutive cycles, then settles.
REQ-032 SHALL count the bounce cycles inside period P; with bounce enabled, P values below 3 are treated as 3.
REQ-033 SHALL, without QUAD_ENC_TX_BOUNCE_EN, produce clean single edges with no extra logic.

Structure
REQ-034 SHALL place in shared package quad_enc_pkg: the state enum (IDLE, RUN, HOLD), the forward and reverse Gray lookup constants, and the minimum-period constants (1, and 3 for bounce).
REQ-035 SHALL use one sub-module, quad_enc_timer: a loadable period down-counter that produces a one-cycle tick every P cycles and reloads on the tick or on a start.
REQ-036 SHALL keep the RTL within 120-400 lines.

Verification
REQ-037 SHALL test: reset, then cmd dir=1, steps=4, period=5 -> AB 10,11,01,00 at cycles 5,10,15,20 after the handshake; done at cycle 25; busy high in cycles 1-25.
REQ-038 SHALL test: from phase 00, cmd dir=0, steps=2, period=1 -> AB 01 then 11 on consecutive cycles; done 2 cycles later; the next cmd dir=1, steps=1 -> AB 01.
REQ-039 SHALL test: cmd steps=0, period=3 -> no enc edge; done pulses 3 cycles after the handshake.
REQ-040 SHALL test: cmd steps=255, period=0 -> 255 transitions with 1-cycle spacing; final phase index 255 mod 4 = 3 (AB 01 forward).
REQ-041 SHALL test: reset_n low at the 3rd transition of steps=10 -> AB 00 the next cycle; no done; cmd_ready high after reset release.
REQ-042 SHALL test, with QUAD_ENC_TX_BOUNCE_EN defined: steps=1, period=8 from 00 -> enc_a 1,0,1 on cycles 8,9,10; enc_b stays 0; done at cycle 16.
